csdac_ctrl: RTL and testbench
=============================

Name: csdac_ctrl

Overview:
Digital controller for the 17-thermometric + 6-binary current-steering DAC cell. It sequences power-up (pdb), runs a linear trim search on the calibration current (dataical) against an external comparator, then accepts DAC codes over a valid/ready handshake. Each code is segmented into registered complementary thermometric and binary controls. It also gates the analog test-bus enables. It sits between the digital datapath and the analog DAC macro.

Parameters:
PWRUP_CYC, 16, cycles pdb is held high with a zero code before leaving PWRUP (>=1)
CAL_SETTLE, 8, cycles each dataical step is held before cal_cmp is sampled (>=1)
CAL_MAX, 22, last dataical value tried in the search (<=31)
CAL_DEFAULT, 11, dataical used after reset, power-down and calibration failure
AUTO_CAL, 1, 1: PWRUP goes to CAL; 0: PWRUP goes to RUN

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  block enable; 0 forces power-down
code_valid  in  1  code offered
code  in  11  DAC code, LSB units; thermometric unit = 64 LSB
red_en  in  1  redundant LSB cell request, captured with code
code_ready  out  1  code accepted this cycle when code_valid=1
cal_start  in  1  request recalibration (used in RUN only)
cal_cmp  in  1  comparator result, synchronous to clk; 1 = Ical at or above target
atb_sel  in  2  requested test-bus selection
atest_req  in  1  requested analog test enable
pdb  out  1  DAC power-down bar
datain  out  7  [5:0] binary cells, [6] redundant LSB cell
datainb  out  7  bitwise complement of datain
datatherm  out  17  thermometric cells
datathermb  out  17  bitwise complement of datatherm
dataical  out  5  calibration trim
atb_ena  out  2  test-bus select to DAC
atest_ena  out  1  analog test enable to DAC
cal_done  out  1  last calibration locked
cal_fail  out  1  last calibration exhausted without lock
busy  out  1  state is not RUN

Behaviour:
- All outputs registered except code_ready.
- Reset values: pdb=0, datain=0, datainb=7'h7F, datatherm=0, datathermb=17'h1FFFF, dataical=CAL_DEFAULT, atb_ena=0, atest_ena=0, cal_done=0, cal_fail=0, busy=1. State is OFF.
- States are OFF, PWRUP, CAL and RUN.
- en=0 in any state: next state is OFF, and all outputs take their reset values. This has priority over every other event, including a calibration in progress.
- OFF -> PWRUP when en=1. pdb=1 from the first PWRUP cycle. The code is held at zero.
- PWRUP lasts exactly PWRUP_CYC cycles, then goes to CAL if AUTO_CAL=1, otherwise to RUN.
- CAL entry: dataical=0, cal_done=0, cal_fail=0, cell code forced to zero.
- Each CAL step holds dataical for CAL_SETTLE cycles, then samples cal_cmp on the last cycle of the step:
  - cal_cmp=1: keep dataical, cal_done=1, go to RUN.
  - cal_cmp=0 and dataical=CAL_MAX: dataical=CAL_DEFAULT, cal_fail=1, go to RUN.
  - Otherwise: dataical+1, start the next step.
- RUN: code_ready = (state==RUN) & ~cal_start & en, combinational.
- On accept, the next cycle shows the new code (latency 1). The previous code is held until the next accept.
- Code segmentation: clamp the code to CODE_MAX=1151. Thermometric count t = c[10:6] (0..17); datatherm = (1<<t)-1. datain[5:0] = c[5:0]; datain[6] = red_en.
- Complements are always the exact bitwise inverse of the true outputs, with no skew cycle.
- cal_start in RUN: go to CAL next cycle. If code_valid is also high, the code is not accepted (ready=0). The last code is discarded and cells are forced to zero in CAL.
- atb_ena/atest_ena follow atb_sel/atest_req with 1-cycle latency in PWRUP, CAL and RUN. They are forced to 0 in OFF.
- rst mid-operation: reset values next cycle, regardless of state.

Decomposition:
- csdac_pkg holds:
  - state enum (OFF, PWRUP, CAL, RUN);
  - localparams NTHERM=17, NBIN=6, CODE_W=11, CODE_MAX=1151, ICAL_W=5.
- One combinational sub-module, csdac_seg_enc: clamps and segments a code into datatherm[16:0] and the binary bits.
- FSM, counters and output registers live in csdac_ctrl.

Test Plan:
1. Power-up: rst, then en=1 with AUTO_CAL=0 → pdb=1 on the cycle after en is sampled; busy=1 for 16 cycles, then 0; code_ready rises with RUN.
2. Calibration lock: AUTO_CAL=1, cal_cmp driven 1 when dataical>=9 → steps 0..9, each held 8 cycles; final dataical=9, cal_done=1, cal_fail=0.
3. Calibration failure: cal_cmp=0 throughout → dataical reaches 22, then dataical=11, cal_fail=1, cal_done=0, state RUN.
4. Segmentation:
   - code=357, red_en=0 → datatherm=17'h0001F, datain=7'b0100101, datainb=7'b1011010.
   - code=1151 → datatherm=17'h1FFFF, datain[5:0]=6'h3F.
   - code=2000 → same outputs as code=1151.
   - code=0, red_en=1 → datain=7'b1000000.
5. Collision: cal_start and code_valid in the same RUN cycle → code_ready=0, CAL next cycle, cell outputs zero, old code not restored.
6. Abort: en=0 during the fourth CAL step → next cycle pdb=0, dataical=11, cal_done=0, datathermb=17'h1FFFF; re-enabling repeats the full PWRUP.

Source files
------------

// File: rtl/csdac_pkg.sv
// Shared types and sizes for the current-steering DAC controller.
//   state_t : controller states
//   NTHERM/NBIN/CODE_W/CODE_MAX/ICAL_W : cell and code geometry
package csdac_pkg;

  localparam int unsigned NTHERM   = 17;
  localparam int unsigned NBIN     = 6;
  localparam int unsigned CODE_W   = 11;
  localparam int unsigned CODE_MAX = 1151;
  localparam int unsigned ICAL_W   = 5;
  localparam int unsigned TCNT_W   = CODE_W - NBIN;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_PWRUP,
    ST_CAL,
    ST_RUN
  } state_t;

endpackage

// File: rtl/csdac_seg_enc.sv
// Clamps a DAC code and splits it into thermometric and binary cell controls.
//   code   : input code in LSB units (64 LSB per thermometric cell)
//   red_en : redundant LSB cell request, placed at bin[6]
//   therm  : thermometric cells, t = clamped[10:6] ones from bit 0
//   bin    : {red_en, clamped[5:0]}
module csdac_seg_enc
  import csdac_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic              red_en,
  output logic [NTHERM-1:0] therm,
  output logic [NBIN:0]     bin
);

  logic [CODE_W-1:0] clamped;
  logic [TCNT_W-1:0] tcnt;

  // Clamping to CODE_MAX keeps tcnt within 0..NTHERM.
  always_comb begin
    clamped = (code > CODE_W'(CODE_MAX)) ? CODE_W'(CODE_MAX) : code;
    tcnt    = clamped[CODE_W-1:NBIN];
    for (int i = 0; i < NTHERM; i++) begin
      therm[i] = (tcnt > TCNT_W'(i));
    end
    bin = {red_en, clamped[NBIN-1:0]};
  end

endmodule

// File: rtl/csdac_ctrl.sv
// Power-up sequencer, linear trim calibration and code interface for the DAC.
//   clk/rst              : clock, synchronous active-high reset
//   en                   : block enable, 0 forces power-down
//   code_valid/code/red_en/code_ready : code handshake
//   cal_start/cal_cmp    : recalibration request, comparator result
//   atb_sel/atest_req    : requested analog test-bus controls
//   pdb, datain(b), datatherm(b), dataical, atb_ena, atest_ena : DAC macro controls
//   cal_done/cal_fail/busy : status
module csdac_ctrl
  import csdac_pkg::*;
#(
  parameter int unsigned PWRUP_CYC   = 16,
  parameter int unsigned CAL_SETTLE  = 8,
  parameter int unsigned CAL_MAX     = 22,
  parameter int unsigned CAL_DEFAULT = 11,
  parameter int unsigned AUTO_CAL    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code,
  input  logic              red_en,
  output logic              code_ready,
  input  logic              cal_start,
  input  logic              cal_cmp,
  input  logic [1:0]        atb_sel,
  input  logic              atest_req,
  output logic              pdb,
  output logic [NBIN:0]     datain,
  output logic [NBIN:0]     datainb,
  output logic [NTHERM-1:0] datatherm,
  output logic [NTHERM-1:0] datathermb,
  output logic [ICAL_W-1:0] dataical,
  output logic [1:0]        atb_ena,
  output logic              atest_ena,
  output logic              cal_done,
  output logic              cal_fail,
  output logic              busy
);

  localparam int unsigned CNT_W = 16;

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic                pdb_q, pdb_n;
  logic [NBIN:0]       datain_q, datain_n, datainb_q;
  logic [NTHERM-1:0]   datatherm_q, datatherm_n, datathermb_q;
  logic [ICAL_W-1:0]   dataical_q, dataical_n;
  logic [1:0]          atb_q, atb_n;
  logic                atest_q, atest_n;
  logic                done_q, done_n;
  logic                fail_q, fail_n;
  logic                busy_q, busy_n;
  logic                cal_enter;
  logic [NTHERM-1:0]   seg_therm;
  logic [NBIN:0]       seg_bin;

  csdac_seg_enc u_seg (
    .code   (code),
    .red_en (red_en),
    .therm  (seg_therm),
    .bin    (seg_bin)
  );

  assign code_ready = (state_q == ST_RUN) & ~cal_start & en;

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    pdb_n       = pdb_q;
    datain_n    = datain_q;
    datatherm_n = datatherm_q;
    dataical_n  = dataical_q;
    done_n      = done_q;
    fail_n      = fail_q;
    cal_enter   = 1'b0;

    case (state_q)
      ST_OFF: begin
        state_n = ST_PWRUP;
        cnt_n   = '0;
        pdb_n   = 1'b1;
      end
      ST_PWRUP: begin
        if (cnt_q == CNT_W'(PWRUP_CYC - 1)) begin
          cnt_n = '0;
          if (AUTO_CAL != 0) begin
            state_n   = ST_CAL;
            cal_enter = 1'b1;
          end else begin
            state_n = ST_RUN;
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      ST_CAL: begin
        // Comparator is only trusted on the last settle cycle of a step.
        if (cnt_q == CNT_W'(CAL_SETTLE - 1)) begin
          cnt_n = '0;
          if (cal_cmp) begin
            state_n = ST_RUN;
            done_n  = 1'b1;
          end else if (dataical_q == ICAL_W'(CAL_MAX)) begin
            state_n    = ST_RUN;
            dataical_n = ICAL_W'(CAL_DEFAULT);
            fail_n     = 1'b1;
          end else begin
            dataical_n = dataical_q + ICAL_W'(1);
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        // Recalibration wins over a simultaneous code offer.
        if (cal_start) begin
          state_n   = ST_CAL;
          cnt_n     = '0;
          cal_enter = 1'b1;
        end else if (code_valid) begin
          datain_n    = seg_bin;
          datatherm_n = seg_therm;
        end
      end
      default: state_n = ST_OFF;
    endcase

    if (cal_enter) begin
      dataical_n  = '0;
      done_n      = 1'b0;
      fail_n      = 1'b0;
      datain_n    = '0;
      datatherm_n = '0;
    end

    // Disable overrides everything, including a calibration in progress.
    if (!en) begin
      state_n     = ST_OFF;
      cnt_n       = '0;
      pdb_n       = 1'b0;
      datain_n    = '0;
      datatherm_n = '0;
      dataical_n  = ICAL_W'(CAL_DEFAULT);
      done_n      = 1'b0;
      fail_n      = 1'b0;
    end

    atb_n   = (state_n != ST_OFF) ? atb_sel : 2'b00;
    atest_n = (state_n != ST_OFF) ? atest_req : 1'b0;
    busy_n  = (state_n != ST_RUN);
  end

  // State and output registers; complements come from the same next value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      pdb_q        <= 1'b0;
      datain_q     <= '0;
      datainb_q    <= '1;
      datatherm_q  <= '0;
      datathermb_q <= '1;
      dataical_q   <= ICAL_W'(CAL_DEFAULT);
      atb_q        <= 2'b00;
      atest_q      <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      pdb_q        <= pdb_n;
      datain_q     <= datain_n;
      datainb_q    <= ~datain_n;
      datatherm_q  <= datatherm_n;
      datathermb_q <= ~datatherm_n;
      dataical_q   <= dataical_n;
      atb_q        <= atb_n;
      atest_q      <= atest_n;
      done_q       <= done_n;
      fail_q       <= fail_n;
      busy_q       <= busy_n;
    end
  end

  assign pdb        = pdb_q;
  assign datain     = datain_q;
  assign datainb    = datainb_q;
  assign datatherm  = datatherm_q;
  assign datathermb = datathermb_q;
  assign dataical   = dataical_q;
  assign atb_ena    = atb_q;
  assign atest_ena  = atest_q;
  assign cal_done   = done_q;
  assign cal_fail   = fail_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_csdac_ctrl.sv
// Testbench for csdac_ctrl: directed power-up/calibration/segmentation/abort
// scenarios followed by randomized traffic, all checked against a behavioural model.
module tb_csdac_ctrl;

  localparam int P_PWRUP  = 16;
  localparam int P_SETTLE = 8;
  localparam int P_CALMAX = 22;
  localparam int P_CALDEF = 11;
  localparam int M_OFF = 0, M_PWRUP = 1, M_CAL = 2, M_RUN = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        code_valid = 1'b0;
  logic [10:0] code = '0;
  logic        red_en = 1'b0;
  logic        cal_start = 1'b0;
  logic        cal_cmp = 1'b0;
  logic [1:0]  atb_sel = 2'b00;
  logic        atest_req = 1'b0;

  logic        code_ready, pdb, atest_ena, cal_done, cal_fail, busy;
  logic [6:0]  datain, datainb;
  logic [16:0] datatherm, datathermb;
  logic [4:0]  dataical;
  logic [1:0]  atb_ena;

  logic        code_ready0, pdb0, atest_ena0, cal_done0, cal_fail0, busy0;
  logic [6:0]  datain0, datainb0;
  logic [16:0] datatherm0, datathermb0;
  logic [4:0]  dataical0;
  logic [1:0]  atb_ena0;

  int n_checks = 0;
  int n_fail = 0;
  int cmp_thresh = 9;

  always #5 clk = ~clk;

  csdac_ctrl #(.PWRUP_CYC(P_PWRUP), .CAL_SETTLE(P_SETTLE), .CAL_MAX(P_CALMAX),
               .CAL_DEFAULT(P_CALDEF), .AUTO_CAL(1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .code_valid(code_valid), .code(code),
    .red_en(red_en), .code_ready(code_ready), .cal_start(cal_start),
    .cal_cmp(cal_cmp), .atb_sel(atb_sel), .atest_req(atest_req), .pdb(pdb),
    .datain(datain), .datainb(datainb), .datatherm(datatherm),
    .datathermb(datathermb), .dataical(dataical), .atb_ena(atb_ena),
    .atest_ena(atest_ena), .cal_done(cal_done), .cal_fail(cal_fail), .busy(busy)
  );

  csdac_ctrl #(.PWRUP_CYC(P_PWRUP), .CAL_SETTLE(P_SETTLE), .CAL_MAX(P_CALMAX),
               .CAL_DEFAULT(P_CALDEF), .AUTO_CAL(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .code_valid(code_valid), .code(code),
    .red_en(red_en), .code_ready(code_ready0), .cal_start(cal_start),
    .cal_cmp(cal_cmp), .atb_sel(atb_sel), .atest_req(atest_req), .pdb(pdb0),
    .datain(datain0), .datainb(datainb0), .datatherm(datatherm0),
    .datathermb(datathermb0), .dataical(dataical0), .atb_ena(atb_ena0),
    .atest_ena(atest_ena0), .cal_done(cal_done0), .cal_fail(cal_fail0), .busy(busy0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Comparator emulation: trips once the trim reaches cmp_thresh.
  always @(negedge clk) cal_cmp = (int'(dataical) >= cmp_thresh);

  // Behavioural model: mode plus cycles elapsed in that mode.
  int m_mode = M_OFF, m_el = 0, m_ical = P_CALDEF;
  int m_therm = 0, m_bin = 0, m_atb = 0;
  bit m_pdb = 0, m_done = 0, m_fail = 0, m_atest = 0;

  task automatic m_enter_cal();
    m_mode = M_CAL; m_el = 0; m_ical = 0; m_done = 0; m_fail = 0;
    m_therm = 0; m_bin = 0;
  endtask

  always @(posedge clk) begin
    int c;
    if (rst || !en) begin
      m_mode = M_OFF; m_el = 0; m_pdb = 0; m_therm = 0; m_bin = 0;
      m_ical = P_CALDEF; m_done = 0; m_fail = 0;
    end else begin
      case (m_mode)
        M_OFF: begin m_mode = M_PWRUP; m_el = 0; m_pdb = 1; end
        M_PWRUP: begin
          m_el++;
          if (m_el == P_PWRUP) m_enter_cal();
        end
        M_CAL: begin
          if (m_el % P_SETTLE == P_SETTLE - 1) begin
            if (cal_cmp) begin m_mode = M_RUN; m_done = 1; end
            else if (m_el / P_SETTLE == P_CALMAX) begin
              m_mode = M_RUN; m_ical = P_CALDEF; m_fail = 1;
            end else m_ical = m_el / P_SETTLE + 1;
          end
          m_el++;
        end
        default: begin
          if (cal_start) m_enter_cal();
          else if (code_valid) begin
            c = (int'(code) > 1151) ? 1151 : int'(code);
            m_therm = (1 << (c / 64)) - 1;
            m_bin = (int'(red_en) << 6) | (c % 64);
          end
        end
      endcase
    end
    if (rst) m_mode = M_OFF;
    m_atb   = (m_mode != M_OFF) ? int'(atb_sel) : 0;
    m_atest = (m_mode != M_OFF) ? atest_req : 1'b0;
  end

  // Compare every cycle, after the DUT registers have settled.
  always @(posedge clk) begin
    #1;
    chk("pdb", 32'(pdb), 32'(m_pdb));
    chk("datain", 32'(datain), 32'(m_bin));
    chk("datainb", 32'(datainb), 32'(~m_bin & 32'h7F));
    chk("datatherm", 32'(datatherm), 32'(m_therm));
    chk("datathermb", 32'(datathermb), 32'(~m_therm & 32'h1FFFF));
    chk("dataical", 32'(dataical), 32'(m_ical));
    chk("atb_ena", 32'(atb_ena), 32'(m_atb));
    chk("atest_ena", 32'(atest_ena), 32'(m_atest));
    chk("cal_done", 32'(cal_done), 32'(m_done));
    chk("cal_fail", 32'(cal_fail), 32'(m_fail));
    chk("busy", 32'(busy), 32'(m_mode != M_RUN));
    chk("code_ready", 32'(code_ready), 32'((m_mode == M_RUN) && !cal_start && en));
  end

  task automatic apply_code(input int c, input bit r);
    code_valid = 1'b1; code = 11'(c); red_en = r;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  // Counts busy cycles of the main DUT until it returns to RUN.
  task automatic wait_run(input int bound, output int nbusy, output bit ok);
    int g = 0;
    nbusy = 0;
    while (busy && g < bound) begin
      nbusy++; g++;
      @(negedge clk);
    end
    ok = (g < bound);
  endtask

  initial begin
    int n, n0, g;
    bit ok, r0_seen;

    // Reset values
    atb_sel = 2'b10; atest_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pdb", 32'(pdb), 0);
    chk("rst_datainb", 32'(datainb), 32'h7F);
    chk("rst_datathermb", 32'(datathermb), 32'h1FFFF);
    chk("rst_dataical", 32'(dataical), 11);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_atb", 32'(atb_ena), 0);

    // Power-up on both DUTs; main one auto-calibrates, locking at trim 9
    rst = 1'b0; en = 1'b1; cmp_thresh = 9;
    @(negedge clk);
    chk("pwrup_pdb", 32'(pdb), 1);
    chk("pwrup_pdb0", 32'(pdb0), 1);
    chk("pwrup_atb", 32'(atb_ena), 2);
    n = 0; n0 = 0; g = 0; r0_seen = 0;
    while ((busy || busy0) && g < 300) begin
      if (busy) n++;
      if (busy0) n0++;
      if (!busy0 && !r0_seen) begin
        chk("run0_ready", 32'(code_ready0), 1);
        r0_seen = 1;
      end
      g++;
      @(negedge clk);
    end
    chk("pwrup_timeout", 32'(g < 300), 1);
    chk("busy0_cycles", 32'(n0), 16);
    chk("cal_lock_cycles", 32'(n), 16 + 10 * 8);
    chk("lock_ical", 32'(dataical), 9);
    chk("lock_done", 32'(cal_done), 1);
    chk("lock_fail", 32'(cal_fail), 0);

    // Segmentation
    apply_code(357, 0);
    chk("seg357_therm", 32'(datatherm), 32'h0001F);
    chk("seg357_din", 32'(datain), 32'b0100101);
    chk("seg357_dinb", 32'(datainb), 32'b1011010);
    apply_code(1151, 0);
    chk("seg1151_therm", 32'(datatherm), 32'h1FFFF);
    chk("seg1151_din", 32'(datain), 32'h3F);
    apply_code(2000, 0);
    chk("seg2000_therm", 32'(datatherm), 32'h1FFFF);
    chk("seg2000_din", 32'(datain), 32'h3F);
    apply_code(0, 1);
    chk("seg0_din", 32'(datain), 32'b1000000);
    chk("seg0_therm", 32'(datatherm), 0);
    apply_code(357, 0);

    // Collision, then a calibration that never locks
    cmp_thresh = 32;
    cal_start = 1'b1; code_valid = 1'b1; code = 11'd1000;
    #1 chk("collide_ready", 32'(code_ready), 0);
    @(negedge clk);
    cal_start = 1'b0; code_valid = 1'b0;
    chk("collide_busy", 32'(busy), 1);
    chk("collide_therm", 32'(datatherm), 0);
    chk("collide_din", 32'(datain), 0);
    chk("collide_ical", 32'(dataical), 0);
    wait_run(400, n, ok);
    chk("fail_timeout", 32'(ok), 1);
    chk("fail_cycles", 32'(n), 23 * 8);
    chk("fail_ical", 32'(dataical), 11);
    chk("fail_flag", 32'(cal_fail), 1);
    chk("fail_done", 32'(cal_done), 0);
    chk("fail_therm", 32'(datatherm), 0);

    // Abort during the fourth calibration step
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    g = 0;
    while (dataical != 5'd3 && g < 300) begin g++; @(negedge clk); end
    chk("abort_reach_timeout", 32'(g < 300), 1);
    repeat (2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("abort_pdb", 32'(pdb), 0);
    chk("abort_ical", 32'(dataical), 11);
    chk("abort_done", 32'(cal_done), 0);
    chk("abort_thermb", 32'(datathermb), 32'h1FFFF);
    chk("abort_atb", 32'(atb_ena), 0);
    chk("abort_busy", 32'(busy), 1);
    en = 1'b1; cmp_thresh = 0;
    @(negedge clk);
    wait_run(200, n, ok);
    chk("reen_timeout", 32'(ok), 1);
    chk("reen_cycles", 32'(n), 16 + 8);
    chk("reen_ical", 32'(dataical), 0);
    chk("reen_done", 32'(cal_done), 1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (i % 60 == 0) cmp_thresh = int'($urandom_range(0, 30));
      rst        = ($urandom_range(0, 999) == 0);
      en         = ($urandom_range(0, 399) != 0);
      code_valid = 1'($urandom_range(0, 1));
      code       = 11'($urandom_range(0, 2047));
      red_en     = 1'($urandom_range(0, 1));
      cal_start  = ($urandom_range(0, 59) == 0);
      atb_sel    = 2'($urandom_range(0, 3));
      atest_req  = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
